manch_tx_enc: RTL and testbench
===============================

// Module: manch_tx_enc
// PURPOSE
//  Manchester (IEEE 802.3) serial encoder; sits downstream of the half-bit rate divider (diff_cnt_div).
//  Accepts a parallel word over a valid/ready handshake and serialises it as: start bit '1', DATA_W data bits, [parity].
//  Each bit takes two half-bit periods; each period is marked by a one-cycle tick strobe (divider q_cout).
//  Encoding: bit b -> first half ~b, second half b (0 = high->low, 1 = low->high).
// PARAMETERS
//  DATA_W     8  payload width, 1..16
//  MSB_FIRST  1  1: data[DATA_W-1] sent first; 0: data[0] first
//  IDLE_LVL   0  tx_out level outside frames
// PORTS
//  clk       in   1       system clock, all logic on posedge
//  reset     in   1       synchronous, active-high
//  tick      in   1       half-bit strobe, one clk wide
//  in_data   in   DATA_W  word to send
//  in_valid  in   1       in_data valid
//  in_ready  out  1       encoder can accept a word
//  tx_out    out  1       Manchester line output, registered
//  tx_en     out  1       high for the full frame, registered
//  done      out  1       one-cycle pulse at frame end
// BEHAVIOUR
//  Reset (clk edge with reset=1): state=ST_IDLE, tx_out=IDLE_LVL, tx_en=0, done=0; shift reg, bit_cnt, half cleared.
//  in_ready = (state==ST_IDLE) & ~reset, combinational. Accept = in_valid & in_ready; in_data latched at accept.
//  FSM (package enum): ST_IDLE -> ST_ARM on accept.
//    ST_ARM: waits for the first tick; a tick in the accept cycle is ignored.
//    ST_START -> ST_DATA -> [ST_PAR] -> ST_END.
//  All transitions and tx_out/tx_en updates happen only on cycles with tick=1; otherwise everything holds.
//  ARM + tick: tx_en<=1, tx_out<=0 (start first half), half<=1, go ST_START.
//  Per bit on tick: half==0 -> tx_out<=~b, half<=1; half==1 -> tx_out<=b, half<=0, advance.
//  ST_DATA: bit_cnt counts 0..DATA_W-1; after the second half of the last bit, go ST_PAR or ST_END.
//  ST_END + tick: tx_out<=IDLE_LVL, tx_en<=0, done<=1 for exactly one clk, go ST_IDLE.
//  Frame length from the first tick after accept: 2*(1+DATA_W[+1]) + 1 ticks, e.g. 19 ticks for DATA_W=8, no parity.
//  in_valid while busy: ignored, held by the source (in_ready=0). in_data changes after accept: no effect.
//  Back-to-back: the next accept is possible the cycle after done; there is >=1 idle tick between frames.
//  tick with no frame pending: no effect.
//  Reset mid-frame: frame abandoned, outputs return to reset values next edge, no done pulse.
//  tick every clk (div=1 source): legal, one half-bit per clk.
// CONFIGURATION
//  MANCH_PARITY_EN defined: ST_PAR appends an even-parity bit (^data) after data, Manchester-encoded; frame +2 ticks.
//  MANCH_PARITY_EN undefined: ST_PAR and its logic are absent; ST_DATA goes directly to ST_END.
// STRUCTURE
//  manch_pkg holds:
//    typedef enum logic [2:0] tx_state_t {ST_IDLE, ST_ARM, ST_START, ST_DATA, ST_PAR, ST_END}
//    function manch_half(bit b, bit second) returning the line level
//    localparam START_BIT=1'b1
//  No sub-module. The tick source (diff_cnt_div) is instantiated beside this block by the integrator, not inside it.
// TESTING (DATA_W=8, MSB_FIRST=1, IDLE_LVL=0, tick every 4 clk)
//  1 0xA5, no parity -> tx_out per tick: 01 01 10 01 10 10 01 10 01 then 0. tx_en high 18 ticks; done once.
//  2 MANCH_PARITY_EN, 0xA5 -> as scenario 1 plus parity half-bits 10 before idle. 0x01 -> parity half-bits 01.
//  3 in_valid held high for 3 words -> each accepted only when in_ready=1; 3 frames and 3 done pulses, no word lost or duplicated.
//  4 reset asserted at tick 7 of a frame -> next clk: tx_out=0, tx_en=0, in_ready=1, no done; a new word then sends correctly.
//  5 tick and accept in the same clk -> tx_out stays 0 until the following tick; MSB_FIRST=0 with 0x01 -> first data half-bits 01.
//  6 tick every clk, 0xFF -> 19-clk frame, data half-bits 01 x8, done on clk 19.

Source files
------------

// File: rtl/manch_pkg.sv
// Shared types and helpers for the Manchester line encoder.
// The MANCH_PARITY_EN build option enables the even-parity tail bit.
package manch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_END
  } tx_state_t;

  localparam logic START_BIT = 1'b1;

  // 0 -> high then low, 1 -> low then high
  function automatic logic manch_half(input bit b, input bit second);
    return second ? b : ~b;
  endfunction

endpackage

// File: rtl/manch_tx_enc.sv
// Manchester serial encoder: start bit, DATA_W data bits, optional parity.
// Define MANCH_PARITY_EN to append an even-parity bit after the data.
module manch_tx_enc
  import manch_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_LVL  = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_out,
  output logic              tx_en,
  output logic              done
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  tx_state_t         state;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic              half;
  logic              cur_bit;
  logic              accept;
`ifdef MANCH_PARITY_EN
  logic              par;
`endif

  assign in_ready = (state == ST_IDLE) & ~reset;
  assign accept   = in_valid & in_ready;
  assign cur_bit  = MSB_FIRST ? shreg[DATA_W-1] : shreg[0];

  always_ff @(posedge clk) begin
    done <= 1'b0;
    if (reset) begin
      state   <= ST_IDLE;
      tx_out  <= IDLE_LVL;
      tx_en   <= 1'b0;
      shreg   <= '0;
      bit_cnt <= '0;
      half    <= 1'b0;
`ifdef MANCH_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          // a tick in the accept cycle is deliberately not used
          if (accept) begin
            shreg <= in_data;
`ifdef MANCH_PARITY_EN
            par   <= ^in_data;
`endif
            state <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (tick) begin
            tx_en  <= 1'b1;
            tx_out <= manch_half(START_BIT, 1'b0);
            half   <= 1'b1;
            state  <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            tx_out  <= manch_half(START_BIT, 1'b1);
            half    <= 1'b0;
            bit_cnt <= '0;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick) begin
            tx_out <= manch_half(cur_bit, half);
            half   <= ~half;
            if (half) begin
              shreg <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
              if (bit_cnt == LAST) begin
                bit_cnt <= '0;
`ifdef MANCH_PARITY_EN
                state   <= ST_PAR;
`else
                state   <= ST_END;
`endif
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
        end
`ifdef MANCH_PARITY_EN
        ST_PAR: begin
          if (tick) begin
            tx_out <= manch_half(par, half);
            half   <= ~half;
            if (half) state <= ST_END;
          end
        end
`endif
        ST_END: begin
          if (tick) begin
            tx_out <= IDLE_LVL;
            tx_en  <= 1'b0;
            done   <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_manch_tx_enc.sv
// Scoreboard bench: two encoders (MSB/LSB first, idle low/high) in lockstep.
module tb_manch_tx_enc;

`ifdef MANCH_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic       clk;
  logic       reset;
  logic       tick;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       rdy1;
  logic [1:0] tx_out_v;
  logic [1:0] tx_en_v;
  logic [1:0] done_v;

  int checks = 0;
  int failures = 0;
  int inv_err = 0;
  int tick_div = 4;
  int sent = 0;
  int aborted = 0;
  int frames = 0;

  logic [7:0] exp_q[$];

  manch_tx_enc #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_LVL(1'b0)) u_msb (
    .clk(clk), .reset(reset), .tick(tick), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .tx_out(tx_out_v[0]),
    .tx_en(tx_en_v[0]), .done(done_v[0])
  );

  manch_tx_enc #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_LVL(1'b1)) u_lsb (
    .clk(clk), .reset(reset), .tick(tick), .in_data(in_data),
    .in_valid(in_valid), .in_ready(rdy1), .tx_out(tx_out_v[1]),
    .tx_en(tx_en_v[1]), .done(done_v[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    int cnt;
    cnt = 0;
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cnt++;
      if (cnt >= tick_div) cnt = 0;
      tick = (cnt == 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Reference: start bit, 8 data bits in wire order, optional even parity,
  // each bit emitted as (~b, b); bit 0 of e is the first half-bit.
  function automatic void model(input logic [7:0] w, input bit msb,
                                output logic [31:0] e, output int n);
    int bits[$];
    bits.push_back(1);
    for (int i = 0; i < 8; i++) begin
      int idx;
      idx = msb ? 7 - i : i;
      bits.push_back(int'(w[idx]));
    end
    if (PB == 1) bits.push_back($countones(w) % 2);
    e = '0;
    n = 0;
    foreach (bits[i]) begin
      e[n]     = (bits[i] == 0);
      e[n + 1] = (bits[i] == 1);
      n += 2;
    end
  endfunction

  logic        idl[2];
  bit          msbf[2];
  logic [31:0] cap[2];
  int          ncap[2];
  logic        last_out[2];
  logic        last_en[2];
  logic        last_done[2];
  logic        prev_tk = 1'b0;
  logic        prev_acc = 1'b0;
  logic        prev_rst = 1'b1;
  bit          counting = 0;
  int          tcnt = 0;

  initial begin
    idl[0] = 1'b0; idl[1] = 1'b1;
    msbf[0] = 1'b1; msbf[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cap[k] = '0; ncap[k] = 0;
      last_out[k] = idl[k]; last_en[k] = 1'b0; last_done[k] = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic [31:0] e;
    int n;
    logic [7:0] w;
    if (prev_rst) begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (tx_out_v[k] !== idl[k] || tx_en_v[k] !== 1'b0 || done_v[k] !== 1'b0) begin
          failures++;
          $display("FAIL reset_state inst=%0d got out=%b en=%b done=%b exp out=%b en=0 done=0",
                   k, tx_out_v[k], tx_en_v[k], done_v[k], idl[k]);
        end
        cap[k] = '0;
        ncap[k] = 0;
      end
      checks++;
      if (in_ready !== ~reset) begin
        failures++;
        $display("FAIL reset_ready got=%b exp=%b", in_ready, ~reset);
      end
      counting = 0;
    end else begin
      if (prev_acc) begin
        counting = 1;
        tcnt = 0;
      end else if (prev_tk && counting) begin
        tcnt++;
      end
      for (int k = 0; k < 2; k++) begin
        if (prev_tk && tx_en_v[k] === 1'b1 && ncap[k] < 32) begin
          cap[k][ncap[k]] = tx_out_v[k];
          ncap[k]++;
        end
        if (!prev_tk && (tx_out_v[k] !== last_out[k] || tx_en_v[k] !== last_en[k]
                         || done_v[k] !== 1'b0)) inv_err++;
        if (tx_en_v[k] !== 1'b1 && tx_out_v[k] !== idl[k]) inv_err++;
        if (done_v[k] === 1'b1 && last_done[k] === 1'b1) inv_err++;
      end
      if (done_v[0] === 1'b1 || done_v[1] === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL spurious_done got done=%b exp no frame pending", done_v);
        end else begin
          w = exp_q[0];
          for (int k = 0; k < 2; k++) begin
            model(w, msbf[k], e, n);
            checks++;
            if (done_v[k] !== 1'b1 || ncap[k] != n || cap[k] !== e) begin
              failures++;
              $display("FAIL frame inst=%0d word=%h got=%h/%0d done=%b exp=%h/%0d",
                       k, w, cap[k], ncap[k], done_v[k], e, n);
            end
            checks++;
            if (tcnt != n + 1) begin
              failures++;
              $display("FAIL frame_ticks word=%h got=%0d exp=%0d", w, tcnt, n + 1);
            end
          end
          void'(exp_q.pop_front());
          frames++;
        end
        for (int k = 0; k < 2; k++) begin
          cap[k] = '0;
          ncap[k] = 0;
        end
        counting = 0;
      end
    end
    if (in_ready !== rdy1) inv_err++;
    for (int k = 0; k < 2; k++) begin
      last_out[k] = tx_out_v[k];
      last_en[k] = tx_en_v[k];
      last_done[k] = done_v[k];
    end
    prev_tk = tick;
    prev_acc = in_valid & in_ready;
    prev_rst = reset;
  end

  task automatic send(input logic [7:0] w, input bit keep, input bit align);
    int t;
    if (align) begin
      t = 0;
      do begin
        @(posedge clk);
        #2;
        t++;
      end while (!tick && t < 100);
    end
    in_data = w;
    in_valid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 2000) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout word=%h got in_ready=0 exp 1", w);
        in_valid = 1'b0;
        return;
      end
    end
    exp_q.push_back(w);
    sent++;
    @(posedge clk);
    #1;
    if (!keep) begin
      in_valid = 1'b0;
      in_data = 8'($urandom);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 5000) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout got pending=%0d exp 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit last_keep;
    bit keep;
    int n;
    int t;
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    send(8'hA5, 0, 0);
    send(8'h01, 0, 0);
    wait_idle();

    send(8'h3C, 1, 0);
    send(8'hC3, 1, 0);
    send(8'h5A, 0, 0);
    wait_idle();

    send(8'h96, 0, 0);
    n = 0;
    t = 0;
    while (n < 7 && t < 1000) begin
      @(posedge clk);
      t++;
      if (tick) n++;
    end
    #1 reset = 1'b1;
    aborted += exp_q.size();
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    send(8'h69, 0, 0);
    wait_idle();

    send(8'h01, 0, 1);
    send(8'h80, 0, 1);
    wait_idle();

    tick_div = 1;
    send(8'hFF, 0, 0);
    send(8'h00, 0, 0);
    wait_idle();

    last_keep = 0;
    repeat (25) begin
      tick_div = $urandom_range(1, 5);
      keep = ($urandom_range(0, 1) == 1);
      if (!last_keep) begin
        repeat ($urandom_range(0, 6)) @(posedge clk);
        #1;
        send(8'($urandom), keep, ($urandom_range(0, 1) == 1));
      end else begin
        send(8'($urandom), keep, 0);
      end
      last_keep = keep;
    end
    in_valid = 1'b0;
    wait_idle();
    repeat (10) @(posedge clk);

    checks++;
    if (inv_err != 0) begin
      failures++;
      $display("FAIL invariants got=%0d exp=0", inv_err);
    end
    checks++;
    if (frames != sent - aborted) begin
      failures++;
      $display("FAIL frame_count got=%0d exp=%0d", frames, sent - aborted);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
